// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared definitions for the matrix iteration controller: datapath widths,
// beat counts for the coefficient and seed streams, and the sequencer's
// state encoding.
package matrix_pkg;

   localparam int COEF_W   = 5;
   localparam int X_W      = 32;
   localparam int XN_W     = 8;
   localparam int NUM_COEF = 9;
   localparam int NUM_SEED = 4;

   typedef enum logic [2:0] {
      ST_CFG,
      ST_SET,
      ST_SEED,
      ST_ARMED,
      ST_ISSUE,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/xn_fifo.sv
// xn_fifo
// Synchronous FIFO for the per-iteration output bytes. The head entry is
// held in a dedicated output register, so dout comes straight from a flop.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   full, empty     registered occupancy flags
//   dout            registered head-of-queue data
module xn_fifo
   import matrix_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [XN_W-1:0] din,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [XN_W-1:0] dout
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [XN_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
         count_nxt = count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // The head register is refilled on a pop from the next stored entry, or
   // straight from din when the incoming byte becomes the new head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == (PTR_W+1)'(DEPTH));
         empty <= (count_nxt == '0);
         if (do_pop && (count > (PTR_W+1)'(1))) begin
            dout <= mem[rd_ptr + PTR_W'(1)];
         end else if (do_push && (empty || (do_pop && (count == (PTR_W+1)'(1))))) begin
            dout <= din;
         end
      end
   end

endmodule

// File: rtl/matrix_iter_ctrl.sv
// matrix_iter_ctrl
// Sequencer for the 4x4 coupled-state matrix core. Loads nine coupling
// coefficients and four seed states, latches the coefficients into the core,
// then iterates the core a programmed number of times, feeding each result
// back as the next state and buffering every output byte.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_data      coefficient stream (e12..e34 order)
//   seed_valid/seed_ready/seed_data   seed stream (xp, xs, xl, xti order)
//   run, n_iter                       run request and iteration count
//   e12_o..e34_o, set_o               coefficients and latch pulse to core
//   start_o, xp_o..xti_o              iterate pulse and current state to core
//   core_done, xpn..xtin, xn          result strobe, next state, output byte
//   out_valid/out_ready/out_data      output byte stream
//   busy, run_done                    run in progress, final-capture pulse
module matrix_iter_ctrl
   import matrix_pkg::*;
#(
   parameter int ITER_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [COEF_W-1:0] cfg_data,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic [X_W-1:0]    seed_data,
   input  logic              run,
   input  logic [ITER_W-1:0] n_iter,
   output logic [COEF_W-1:0] e12_o,
   output logic [COEF_W-1:0] e13_o,
   output logic [COEF_W-1:0] e14_o,
   output logic [COEF_W-1:0] e21_o,
   output logic [COEF_W-1:0] e23_o,
   output logic [COEF_W-1:0] e24_o,
   output logic [COEF_W-1:0] e31_o,
   output logic [COEF_W-1:0] e32_o,
   output logic [COEF_W-1:0] e34_o,
   output logic              set_o,
   output logic              start_o,
   output logic [X_W-1:0]    xp_o,
   output logic [X_W-1:0]    xs_o,
   output logic [X_W-1:0]    xl_o,
   output logic [X_W-1:0]    xti_o,
   input  logic              core_done,
   input  logic [X_W-1:0]    xpn,
   input  logic [X_W-1:0]    xsn,
   input  logic [X_W-1:0]    xln,
   input  logic [X_W-1:0]    xtin,
   input  logic [XN_W-1:0]   xn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XN_W-1:0]   out_data,
   output logic              busy,
   output logic              run_done
);

   state_t              state;
   logic [COEF_W-1:0]   coef [NUM_COEF];
   logic [3:0]          cfg_idx;
   logic [1:0]          seed_idx;
   logic [ITER_W-1:0]   iter_left;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;

   assign e12_o = coef[0];
   assign e13_o = coef[1];
   assign e14_o = coef[2];
   assign e21_o = coef[3];
   assign e23_o = coef[4];
   assign e24_o = coef[5];
   assign e31_o = coef[6];
   assign e32_o = coef[7];
   assign e34_o = coef[8];

   // Handshake and strobe outputs are decodes of the state register. A start
   // is only issued while the FIFO has room, which guarantees space for the
   // single outstanding result.
   assign cfg_ready  = (state == ST_CFG);
   assign seed_ready = (state == ST_SEED);
   assign set_o      = (state == ST_SET);
   assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
   assign start_o    = (state == ST_ISSUE) && !fifo_full;
   assign fifo_push  = (state == ST_WAIT) && core_done;
   assign out_valid  = !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_CFG;
         cfg_idx   <= '0;
         seed_idx  <= '0;
         iter_left <= '0;
         xp_o      <= '0;
         xs_o      <= '0;
         xl_o      <= '0;
         xti_o     <= '0;
         run_done  <= 1'b0;
         for (int i = 0; i < NUM_COEF; i++) begin
            coef[i] <= '0;
         end
      end else begin
         run_done <= 1'b0;
         unique case (state)
            ST_CFG: begin
               if (cfg_valid) begin
                  coef[cfg_idx] <= cfg_data;
                  if (cfg_idx == 4'(NUM_COEF-1)) begin
                     cfg_idx <= '0;
                     state   <= ST_SET;
                  end else begin
                     cfg_idx <= cfg_idx + 4'd1;
                  end
               end
            end
            ST_SET: begin
               state <= ST_SEED;
            end
            ST_SEED: begin
               if (seed_valid) begin
                  unique case (seed_idx)
                     2'd0:    xp_o  <= seed_data;
                     2'd1:    xs_o  <= seed_data;
                     2'd2:    xl_o  <= seed_data;
                     default: xti_o <= seed_data;
                  endcase
                  seed_idx <= seed_idx + 2'd1;
                  if (seed_idx == 2'(NUM_SEED-1)) begin
                     state <= ST_ARMED;
                  end
               end
            end
            // A zero-length run request still takes priority and is
            // simply dropped, leaving the sequencer armed.
            ST_ARMED: begin
               if (run) begin
                  if (n_iter != '0) begin
                     iter_left <= n_iter;
                     state     <= ST_ISSUE;
                  end
               end else if (cfg_valid) begin
                  state <= ST_CFG;
               end else if (seed_valid) begin
                  state <= ST_SEED;
               end
            end
            ST_ISSUE: begin
               if (!fifo_full) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (core_done) begin
                  xp_o      <= xpn;
                  xs_o      <= xsn;
                  xl_o      <= xln;
                  xti_o     <= xtin;
                  iter_left <= iter_left - ITER_W'(1);
                  if (iter_left == ITER_W'(1)) begin
                     run_done <= 1'b1;
                     state    <= ST_ARMED;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            default: begin
               state <= ST_CFG;
            end
         endcase
      end
   end

   xn_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_xn_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (xn),
      .pop   (out_valid && out_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (out_data)
   );

endmodule

// File: tb/tb_matrix_iter_ctrl.sv
// tb_matrix_iter_ctrl
// Directed-sequence bench for matrix_iter_ctrl with a behavioural stub of the
// matrix core. Coefficients and seeds are randomised; expected byte streams
// and final states come from an iteration model of the stub core applied to
// the loaded values.
module tb_matrix_iter_ctrl;
   import matrix_pkg::*;

   localparam int ITER_W     = 16;
   localparam int FIFO_DEPTH = 4;

   typedef struct packed {
      logic [31:0] xp;
      logic [31:0] xs;
      logic [31:0] xl;
      logic [31:0] xti;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [4:0]        cfg_data;
   logic              seed_valid;
   logic              seed_ready;
   logic [31:0]       seed_data;
   logic              run;
   logic [ITER_W-1:0] n_iter;
   logic [4:0]        e12_o, e13_o, e14_o, e21_o, e23_o, e24_o, e31_o, e32_o, e34_o;
   logic              set_o;
   logic              start_o;
   logic [31:0]       xp_o, xs_o, xl_o, xti_o;
   logic              core_done;
   logic [31:0]       xpn, xsn, xln, xtin;
   logic [7:0]        xn;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic              busy;
   logic              run_done;

   always #5 clk = ~clk;

   matrix_iter_ctrl #(
      .ITER_W     (ITER_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_data   (cfg_data),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .seed_data  (seed_data),
      .run        (run),
      .n_iter     (n_iter),
      .e12_o      (e12_o),
      .e13_o      (e13_o),
      .e14_o      (e14_o),
      .e21_o      (e21_o),
      .e23_o      (e23_o),
      .e24_o      (e24_o),
      .e31_o      (e31_o),
      .e32_o      (e32_o),
      .e34_o      (e34_o),
      .set_o      (set_o),
      .start_o    (start_o),
      .xp_o       (xp_o),
      .xs_o       (xs_o),
      .xl_o       (xl_o),
      .xti_o      (xti_o),
      .core_done  (core_done),
      .xpn        (xpn),
      .xsn        (xsn),
      .xln        (xln),
      .xtin       (xtin),
      .xn         (xn),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .run_done   (run_done)
   );

   // Stub core behaviour: one fixed arithmetic step of the coupled state.
   function automatic vec_t next_vec(vec_t v, logic [8:0][4:0] e);
      vec_t r;
      r.xp  = v.xp * 32'd5 + v.xs + 32'(e[0]);
      r.xs  = v.xs ^ (v.xl + 32'(e[3]));
      r.xl  = v.xl + v.xti + 32'(e[6]);
      r.xti = v.xti + 32'd1 + 32'(e[8]);
      return r;
   endfunction

   function automatic logic [7:0] out_byte(vec_t v, logic [8:0][4:0] e);
      return v.xp[7:0] ^ v.xs[15:8] ^ v.xl[23:16] ^ v.xti[31:24] ^ {3'b000, e[1]};
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      r.xp  = $urandom();
      r.xs  = $urandom();
      r.xl  = $urandom();
      r.xti = $urandom();
      return r;
   endfunction

   vec_t            dut_vec;
   logic [8:0][4:0] dut_e;
   bit              fixed_mode;

   assign dut_vec = {xp_o, xs_o, xl_o, xti_o};
   assign dut_e   = {e34_o, e32_o, e31_o, e24_o, e23_o, e21_o, e14_o, e13_o, e12_o};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_done <= 1'b0;
         xpn       <= '0;
         xsn       <= '0;
         xln       <= '0;
         xtin      <= '0;
         xn        <= '0;
      end else begin
         core_done <= start_o;
         if (start_o) begin
            if (fixed_mode) begin
               xpn  <= 32'h10;
               xsn  <= 32'h20;
               xln  <= 32'h30;
               xtin <= 32'h40;
               xn   <= 8'hA5;
            end else begin
               {xpn, xsn, xln, xtin} <= next_vec(dut_vec, dut_e);
               xn <= out_byte(dut_vec, dut_e);
            end
         end
      end
   end

   int              total = 0;
   int              bad = 0;
   int              cyc, start_cnt, set_cnt, done_cnt, push_cnt;
   int              occ, max_occ, last_start, min_gap;
   logic [7:0]      got [$];
   logic [7:0]      expq [$];
   vec_t            mv;
   logic [8:0][4:0] me;

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Books this cycle's push/pop, crosses one clock edge and samples the
   // strobes of the new cycle.
   task automatic apply_stimulus();
      logic pop;
      pop = out_valid && out_ready;
      if (pop) got.push_back(out_data);
      if (core_done) begin
         push_cnt++;
         occ++;
      end
      if (pop) occ--;
      if (occ > max_occ) max_occ = occ;
      @(posedge clk);
      #1;
      cyc++;
      if (start_o) begin
         if (cyc - last_start < min_gap) min_gap = cyc - last_start;
         last_start = cyc;
         start_cnt++;
      end
      if (set_o) set_cnt++;
      if (run_done) done_cnt++;
   endtask

   task automatic model_run(input int n);
      for (int k = 0; k < n; k++) begin
         expq.push_back(out_byte(mv, me));
         mv = next_vec(mv, me);
      end
   endtask

   task automatic load_cfg(input logic [8:0][4:0] e);
      int n;
      me = e;
      for (int k = 0; k < NUM_COEF; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = e[k];
         n = 0;
         while (!cfg_ready && n < 50) begin
            apply_stimulus();
            n++;
         end
         check_output("cfg_handshake", cfg_ready, 1);
         apply_stimulus();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic load_seed(input vec_t v);
      logic [31:0] beats [4];
      int n;
      mv = v;
      beats[0] = v.xp;
      beats[1] = v.xs;
      beats[2] = v.xl;
      beats[3] = v.xti;
      for (int k = 0; k < NUM_SEED; k++) begin
         seed_valid = 1'b1;
         seed_data  = beats[k];
         n = 0;
         while (!seed_ready && n < 50) begin
            apply_stimulus();
            n++;
         end
         check_output("seed_handshake", seed_ready, 1);
         apply_stimulus();
      end
      seed_valid = 1'b0;
   endtask

   task automatic start_run(input int n);
      run    = 1'b1;
      n_iter = ITER_W'(n);
      apply_stimulus();
      run    = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base;
      int k;
      base = done_cnt;
      k = 0;
      while (done_cnt == base && k < budget) begin
         apply_stimulus();
         k++;
      end
      check_output("run_done_seen", done_cnt - base, 1);
   endtask

   task automatic drain(input string tag, input int n, input int budget);
      int k;
      out_ready = 1'b1;
      k = 0;
      while (got.size() < n && k < budget) begin
         apply_stimulus();
         k++;
      end
      check_output({tag, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         check_output($sformatf("%s_byte%0d", tag, i), got[i], expq[i]);
      end
      check_output({tag, "_empty"}, out_valid, 0);
      got.delete();
      expq.delete();
   endtask

   task automatic check_reset(input string tag);
      check_output({tag, "_coef"}, dut_e, 0);
      check_output({tag, "_state"}, dut_vec, 0);
      check_output({tag, "_set"}, set_o, 0);
      check_output({tag, "_start"}, start_o, 0);
      check_output({tag, "_out_valid"}, out_valid, 0);
      check_output({tag, "_out_data"}, out_data, 0);
      check_output({tag, "_busy"}, busy, 0);
      check_output({tag, "_run_done"}, run_done, 0);
      check_output({tag, "_seed_ready"}, seed_ready, 0);
      check_output({tag, "_cfg_ready"}, cfg_ready, 1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0;
      int d0;
      int p0;
      int k;
      vec_t v;
      logic [8:0][4:0] e;

      cfg_valid  = 1'b0;
      cfg_data   = '0;
      seed_valid = 1'b0;
      seed_data  = '0;
      run        = 1'b0;
      n_iter     = '0;
      out_ready  = 1'b0;
      fixed_mode = 1'b1;
      cyc = 0; start_cnt = 0; set_cnt = 0; done_cnt = 0; push_cnt = 0;
      occ = 0; max_occ = 0; last_start = -1000; min_gap = 1000;

      // Reset asserted in the middle of a cycle.
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check_reset("por");
      release_reset();

      // Directed load and single iteration against a constant core.
      for (int i = 0; i < NUM_COEF; i++) e[i] = 5'(i + 1);
      s0 = set_cnt;
      load_cfg(e);
      check_output("set_pulse", set_o, 1);
      check_output("coef_at_set", dut_e, e);
      load_seed({32'd1, 32'd2, 32'd3, 32'd4});
      check_output("set_once", set_cnt - s0, 1);
      check_output("seed_state", dut_vec, {32'd1, 32'd2, 32'd3, 32'd4});
      s0 = start_cnt;
      d0 = done_cnt;
      start_run(1);
      check_output("start_t", start_o, 1);
      check_output("busy_t", busy, 1);
      apply_stimulus();
      apply_stimulus();
      check_output("out_valid_t2", out_valid, 1);
      check_output("out_data_t2", out_data, 8'hA5);
      check_output("xp_after", xp_o, 32'h10);
      check_output("run_done_t2", run_done, 1);
      apply_stimulus();
      apply_stimulus();
      check_output("start_once", start_cnt - s0, 1);
      check_output("run_done_once", done_cnt - d0, 1);
      check_output("busy_after", busy, 0);
      expq.push_back(8'hA5);
      drain("single", 1, 20);

      // Backpressure: FIFO fills after four iterations, then the run stalls.
      fixed_mode = 1'b0;
      for (int i = 0; i < NUM_COEF; i++) e[i] = 5'($urandom_range(0, 31));
      load_cfg(e);
      load_seed(rand_vec());
      out_ready = 1'b0;
      s0 = start_cnt;
      model_run(10);
      start_run(10);
      repeat (30) apply_stimulus();
      check_output("bp_starts_stalled", start_cnt - s0, 4);
      check_output("bp_busy", busy, 1);
      check_output("bp_start_low", start_o, 0);
      check_output("bp_out_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_done(200);
      check_output("bp_starts_total", start_cnt - s0, 10);
      drain("bp", 10, 50);
      check_output("bp_final_state", dut_vec, mv);

      // Streaming: continues from the state left by the previous run.
      s0 = start_cnt;
      max_occ = occ;
      min_gap = 1000;
      last_start = -1000;
      model_run(5);
      start_run(5);
      wait_done(100);
      apply_stimulus();
      check_output("stream_starts", start_cnt - s0, 5);
      check_output("stream_gap", min_gap, 2);
      check_output("stream_max_occ", max_occ, 1);
      drain("stream", 5, 20);
      check_output("stream_final_state", dut_vec, mv);

      // Zero-length run is dropped; the sequencer stays armed.
      s0 = start_cnt;
      d0 = done_cnt;
      start_run(0);
      repeat (5) apply_stimulus();
      check_output("zero_starts", start_cnt - s0, 0);
      check_output("zero_done", done_cnt - d0, 0);
      check_output("zero_busy", busy, 0);
      check_output("zero_cfg_ready", cfg_ready, 0);
      check_output("zero_seed_ready", seed_ready, 0);
      check_output("zero_set", set_o, 0);

      // Reseed from the armed state and run again.
      v = rand_vec();
      load_seed(v);
      check_output("reseed_state", dut_vec, v);
      model_run(3);
      start_run(3);
      wait_done(100);
      drain("reseed", 3, 20);
      check_output("reseed_final_state", dut_vec, mv);

      // Reset in the middle of a ten-iteration run after three captures.
      p0 = push_cnt;
      start_run(10);
      k = 0;
      while (push_cnt - p0 < 3 && k < 100) begin
         apply_stimulus();
         k++;
      end
      check_output("midrun_captures", push_cnt - p0, 3);
      #2 rst_n = 1'b0;
      #1;
      occ = 0;
      got.delete();
      expq.delete();
      check_reset("midrun");
      release_reset();
      check_output("post_reset_cfg_ready", cfg_ready, 1);
      check_output("post_reset_out_valid", out_valid, 0);

      // Fresh load and run after the reset.
      for (int i = 0; i < NUM_COEF; i++) e[i] = 5'($urandom_range(0, 31));
      load_cfg(e);
      check_output("fresh_coef", dut_e, e);
      load_seed(rand_vec());
      d0 = done_cnt;
      model_run(4);
      start_run(4);
      wait_done(100);
      drain("fresh", 4, 20);
      check_output("fresh_final_state", dut_vec, mv);
      check_output("fresh_done_once", done_cnt - d0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_iter_ctrl.md
# matrix_iter_ctrl

Sequencer and driver for the 4x4 coupled-state matrix core. It streams in the nine 5-bit coupling coefficients and the four 32-bit seed states, then pulses the core's `set` and `start` inputs. It feeds each result vector back as the next state for a programmed number of iterations. The 8-bit `xn` output of every iteration is buffered into a byte stream with valid/ready backpressure.

## Interface
- `ITER_W`, default 16: width of the iteration count.
- `FIFO_DEPTH`, default 4: number of `xn` bytes buffered; must be a power of 2, at least 2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid` / `cfg_ready`  in / out  1 / 1  coefficient beat handshake.
- `cfg_data`  in  5  coefficient value; beats arrive in order e12, e13, e14, e21, e23, e24, e31, e32, e34.
- `seed_valid` / `seed_ready`  in / out  1 / 1  seed beat handshake.
- `seed_data`  in  32  seed value; beats arrive in order xp, xs, xl, xti.
- `run`  in  1  single-cycle request to start a run.
- `n_iter`  in  ITER_W  number of iterations; sampled when `run` is accepted.
- `e12_o` … `e34_o`  out  5 each  coefficients driven to the core.
- `set_o`  out  1  one-cycle coefficient latch pulse to the core.
- `start_o`  out  1  one-cycle iterate pulse to the core.
- `xp_o`, `xs_o`, `xl_o`, `xti_o`  out  32 each  current state driven to the core.
- `core_done`  in  1  core result-valid pulse.
- `xpn`, `xsn`, `xln`, `xtin`  in  32 each  next state from the core.
- `xn`  in  8  folded output byte from the core.
- `out_valid` / `out_ready`  out / in  1 / 1  output byte handshake.
- `out_data`  out  8  output byte.
- `busy`  out  1  high while a run is in progress.
- `run_done`  out  1  one-cycle pulse when the last iteration is captured.

## Operation
- **FSM states:** CFG, SET, SEED, ARMED, ISSUE, WAIT. Reset state is CFG.
- **CFG:** `cfg_ready` = 1. Each handshake writes the next coefficient register, indexed by a 4-bit counter.
  - The 9th beat moves the FSM to SET.
- **SET:** `set_o` = 1 for exactly one cycle, then the FSM moves to SEED.
  - `e*_o` hold their values at all times after loading.
- **SEED:** `seed_ready` = 1. Beats write xp, xs, xl, xti in order.
  - The 4th beat moves the FSM to ARMED.
- **ARMED:** sources are checked in priority order:
  - `run` with `n_iter` ≠ 0: latch `n_iter` into `iter_left`, go to ISSUE.
  - `run` with `n_iter` = 0: ignored; no `start_o`, no `run_done`.
  - `cfg_valid`: go to CFG. `cfg_ready` = 0 in ARMED, so no beat is consumed.
  - `seed_valid`: go to SEED.
- **ISSUE:** if the FIFO is not full, drive `start_o` = 1 for one cycle and go to WAIT. Otherwise stall in ISSUE with `start_o` = 0.
- **WAIT:** on `core_done`:
  - Capture `xpn`, `xsn`, `xln`, `xtin` into the state registers.
  - Push `xn` into the FIFO.
  - Decrement `iter_left`. If it reaches 0, pulse `run_done` and go to ARMED; otherwise go to ISSUE.
- **Outstanding requests:** at most one `start_o` is outstanding, so "not full" at issue guarantees room for the push.
- **FIFO:** on a simultaneous push and pop, the count is unchanged. Pop occurs when `out_valid` and `out_ready` are both high.
- **Status outputs:**
  - `busy` = 1 in ISSUE and WAIT.
  - `cfg_valid`, `seed_valid` and `run` are ignored while `busy` is high.
- **Widths:** `iter_left` is ITER_W bits. A run of 2^ITER_W − 1 iterations is supported; the counter does not wrap.
- **Reset (any time, including mid-run):** clears the FSM to CFG, all coefficient and state registers to 0, `iter_left` to 0, and the FIFO to empty. Coefficients and seed must then be reloaded.

## Timing
- **Reset values:**
  - `e*_o`, `xp_o`..`xti_o`, `set_o`, `start_o`, `out_valid`, `out_data`, `busy`, `run_done` are all 0.
  - `seed_ready` is 0.
  - `cfg_ready` is 1, since it decodes state CFG.
- **Configuration:** `set_o` is asserted in the cycle after the 9th cfg handshake.
- **Iteration sequence:**
  - Cycle t: `start_o` = 1.
  - Cycle t+1: the core asserts `core_done`.
  - Edge t+2: state and FIFO are updated.
  - From cycle t+2: `out_valid` = 1, or later if bytes are already queued.
- **Throughput:** one iteration every 2 cycles when unstalled.
- **Stability:** `xp_o`..`xti_o` are stable from ISSUE through WAIT.
- **`run_done`:** asserted in the cycle after the final capture.
- `out_data` is registered FIFO head data.

## Structure
- **Package `matrix_pkg`:**
  - FSM state enum.
  - Constants `COEF_W` = 5, `X_W` = 32, `XN_W` = 8, `NUM_COEF` = 9, `NUM_SEED` = 4.
- **Sub-module `xn_fifo`:** synchronous FIFO of XN_W bits and FIFO_DEPTH entries.
  - Ports: `push`, `pop`, `full`, `empty`, `dout`.
  - Flags and pointers are registered.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle → all outputs at their reset values; `cfg_ready` = 1; `seed_ready` = 0.
- **Load and single run:**
  - Stimulus: cfg beats 1..9, seeds 1, 2, 3, 4, then `run` with `n_iter` = 1. The stub core returns `xn` = 0xA5 and `xpn` = 0x10.
  - Required: `set_o` pulses once with `e12_o` = 1 … `e34_o` = 9.
  - Required: `start_o` pulses once; `out_data` = 0xA5 is valid 2 cycles after `start_o`.
  - Required: `xp_o` = 0x10 afterwards; `run_done` pulses once.
- **Backpressure:** `out_ready` = 0, `n_iter` = 10.
  - Required: exactly 4 `start_o` pulses, then a stall in ISSUE.
  - Then `out_ready` = 1: the remaining 6 iterations complete, and 10 bytes emerge in issue order.
- **Streaming:** `out_ready` = 1 continuously, `n_iter` = 5 → 5 `start_o` pulses on alternate cycles; FIFO count never exceeds 1.
- **Zero count:** `run` with `n_iter` = 0 in ARMED → no `start_o`, no `run_done`; FSM remains in ARMED.
- **Mid-run reset:** reset after 3 captures of a 10-iteration run → outputs return to reset values, FIFO empty, FSM in CFG.
  - Then a fresh load and run yields correct results.
